// File: rtl/flappy_game_ctrl.sv
// Flappy Bird game-state engine: bird physics, tube scroll, gap randomisation, scoring, collision.
// Latency: positions/score update on the edge sampling frame_tick; game_end one edge later.
// No backpressure: frame_tick and flap are single-cycle pulses consumed in the cycle they arrive.
module flappy_game_ctrl #(
    parameter int SCREEN_H     = 480,
    parameter int BIRD_X       = 364,
    parameter int BIRD_HALF    = 15,
    parameter int TUBE_HALF_W  = 30,
    parameter int GAP_HALF     = 30,
    parameter int TUBE_SPACING = 200,
    parameter int TUBE_SPEED   = 2,
    parameter int FLAP_VEL     = 8,
    parameter int GRAVITY      = 1,
    parameter int MAX_FALL     = 8,
    parameter int DEAD_HOLD    = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       flap,
    output logic [9:0] bird_y_pos,
    output logic [9:0] tube1_x_pos,
    output logic [9:0] tube2_x_pos,
    output logic [9:0] tube3_x_pos,
    output logic [9:0] tube1_y_pos,
    output logic [9:0] tube2_y_pos,
    output logic [9:0] tube3_y_pos,
    output logic       game_end,
    output logic [7:0] score
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PLAY  = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_DEAD  = 2'd3;

    typedef logic signed [10:0] s11_t;

    localparam s11_t SCREEN_H_S    = s11_t'(SCREEN_H);
    localparam s11_t BIRD_X_S      = s11_t'(BIRD_X);
    localparam s11_t BIRD_HALF_S   = s11_t'(BIRD_HALF);
    localparam s11_t TUBE_HALF_W_S = s11_t'(TUBE_HALF_W);
    localparam s11_t GAP_HALF_S    = s11_t'(GAP_HALF);
    localparam s11_t FLAP_VEL_S    = s11_t'(FLAP_VEL);
    localparam s11_t GRAVITY_S     = s11_t'(GRAVITY);
    localparam s11_t MAX_FALL_S    = s11_t'(MAX_FALL);

    localparam logic [9:0] BIRD_X_U   = 10'(BIRD_X);
    localparam logic [9:0] Y_CEIL     = 10'(BIRD_HALF);
    localparam logic [9:0] Y_FLOOR    = 10'(SCREEN_H - 1 - BIRD_HALF);
    localparam logic [9:0] WRAP_X     = 10'(TUBE_HALF_W + TUBE_SPEED);
    localparam logic [9:0] WRAP_ADD   = 10'(3 * TUBE_SPACING - TUBE_SPEED);
    localparam logic [9:0] STEP_X     = 10'(TUBE_SPEED);
    // 112 + an 8-bit random value keeps every gap (112..367) well inside the screen
    localparam logic [9:0] GAP_Y_BASE = 10'd112;

    localparam logic [9:0] BIRD_Y0 = 10'd240;
    localparam logic [9:0] T1_X0   = 10'd480;
    localparam logic [9:0] T2_X0   = 10'd680;
    localparam logic [9:0] T3_X0   = 10'd880;
    localparam logic [9:0] T1_Y0   = 10'd240;
    localparam logic [9:0] T2_Y0   = 10'd200;
    localparam logic [9:0] T3_Y0   = 10'd280;

    localparam int              DC_W     = $clog2(DEAD_HOLD + 1);
    localparam logic [DC_W-1:0] HOLD_MAX = DC_W'(DEAD_HOLD);

    logic [1:0]      state_q, state_d;
    logic [9:0]      bird_y_q, bird_y_d;
    s11_t            vel_q, vel_d;
    logic [9:0]      tube1_x_q, tube1_x_d, tube1_y_q, tube1_y_d;
    logic [9:0]      tube2_x_q, tube2_x_d, tube2_y_q, tube2_y_d;
    logic [9:0]      tube3_x_q, tube3_x_d, tube3_y_q, tube3_y_d;
    logic [7:0]      score_q, score_d;
    logic            ground_q, ground_d;
    logic            flap_pend_q, flap_pend_d;
    logic [DC_W-1:0] dead_cnt_q, dead_cnt_d;
    logic            game_end_q, game_end_d;
    logic [7:0]      lfsr_q, lfsr_d;

    s11_t            v_sum, v_new, y_new;
    logic [19:0]     t1_nxt, t2_nxt, t3_nxt;
    logic            hit;

    // One frame of tube motion: scroll left, or jump to the back of the queue with a fresh gap.
    function automatic logic [19:0] tube_step(input logic [9:0] x, input logic [9:0] y,
                                              input logic [7:0] rnd);
        if (x < WRAP_X) begin
            return {x + WRAP_ADD, GAP_Y_BASE + {2'b00, rnd}};
        end
        return {x - STEP_X, y};
    endfunction

    // Saturating score increment when a tube crosses the bird column this frame.
    function automatic logic [7:0] score_inc(input logic [7:0] s, input logic [9:0] old_x,
                                             input logic [9:0] new_x);
        if ((old_x >= BIRD_X_U) && (new_x < BIRD_X_U) && (s != 8'hFF)) begin
            return s + 8'd1;
        end
        return s;
    endfunction

    // Overlap test of the bird box against one tube, treating the gap edges as solid.
    function automatic logic tube_hit(input logic [9:0] tx, input logic [9:0] ty,
                                      input logic [9:0] by);
        s11_t dx, sby, sty;
        dx  = $signed({1'b0, tx}) - BIRD_X_S;
        if (dx[10]) dx = -dx;
        sby = $signed({1'b0, by});
        sty = $signed({1'b0, ty});
        return (dx <= BIRD_HALF_S + TUBE_HALF_W_S) &&
               ((sby - BIRD_HALF_S <= sty - GAP_HALF_S) ||
                (sby + BIRD_HALF_S >= sty + GAP_HALF_S));
    endfunction

    // Candidate tube positions for the next frame and collision on the registered positions.
    always_comb begin
        t1_nxt = tube_step(tube1_x_q, tube1_y_q, lfsr_q);
        t2_nxt = tube_step(tube2_x_q, tube2_y_q, lfsr_q);
        t3_nxt = tube_step(tube3_x_q, tube3_y_q, lfsr_q);
        hit    = tube_hit(tube1_x_q, tube1_y_q, bird_y_q) |
                 tube_hit(tube2_x_q, tube2_y_q, bird_y_q) |
                 tube_hit(tube3_x_q, tube3_y_q, bird_y_q);
        // LFSR free-runs every clock so gap heights depend on player timing
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    // Game FSM: physics and scroll on frame ticks, one-cycle collision check, dead hold-off.
    always_comb begin
        state_d     = state_q;
        bird_y_d    = bird_y_q;
        vel_d       = vel_q;
        tube1_x_d   = tube1_x_q;
        tube1_y_d   = tube1_y_q;
        tube2_x_d   = tube2_x_q;
        tube2_y_d   = tube2_y_q;
        tube3_x_d   = tube3_x_q;
        tube3_y_d   = tube3_y_q;
        score_d     = score_q;
        ground_d    = ground_q;
        flap_pend_d = flap_pend_q;
        dead_cnt_d  = dead_cnt_q;
        game_end_d  = game_end_q;
        v_sum       = '0;
        v_new       = '0;
        y_new       = '0;

        case (state_q)
            S_IDLE: begin
                if (flap) begin
                    flap_pend_d = 1'b1;
                    state_d     = S_PLAY;
                end
            end
            S_PLAY: begin
                if (frame_tick) begin
                    v_sum = vel_q + GRAVITY_S;
                    v_new = flap_pend_q ? -FLAP_VEL_S :
                            ((v_sum > MAX_FALL_S) ? MAX_FALL_S : v_sum);
                    y_new = $signed({1'b0, bird_y_q}) + v_new;
                    if (y_new < BIRD_HALF_S) begin
                        // hitting the ceiling just stops the climb
                        bird_y_d = Y_CEIL;
                        vel_d    = '0;
                    end else if (y_new + BIRD_HALF_S >= SCREEN_H_S) begin
                        bird_y_d = Y_FLOOR;
                        vel_d    = v_new;
                        ground_d = 1'b1;
                    end else begin
                        bird_y_d = y_new[9:0];
                        vel_d    = v_new;
                    end
                    // a flap coinciding with the tick applies to the next frame
                    flap_pend_d = flap;
                    {tube1_x_d, tube1_y_d} = t1_nxt;
                    {tube2_x_d, tube2_y_d} = t2_nxt;
                    {tube3_x_d, tube3_y_d} = t3_nxt;
                    score_d = score_inc(score_inc(score_inc(score_q, tube1_x_q, t1_nxt[19:10]),
                                                  tube2_x_q, t2_nxt[19:10]),
                                        tube3_x_q, t3_nxt[19:10]);
                    state_d = S_CHECK;
                end else if (flap) begin
                    flap_pend_d = 1'b1;
                end
            end
            S_CHECK: begin
                // a frame_tick landing here is dropped
                if (ground_q || hit) begin
                    state_d    = S_DEAD;
                    game_end_d = 1'b1;
                end else begin
                    state_d = S_PLAY;
                end
            end
            default: begin
                if (frame_tick && (dead_cnt_q != HOLD_MAX)) begin
                    dead_cnt_d = dead_cnt_q + DC_W'(1);
                end
                if (flap && (dead_cnt_q == HOLD_MAX)) begin
                    state_d     = S_IDLE;
                    bird_y_d    = BIRD_Y0;
                    vel_d       = '0;
                    tube1_x_d   = T1_X0;
                    tube1_y_d   = T1_Y0;
                    tube2_x_d   = T2_X0;
                    tube2_y_d   = T2_Y0;
                    tube3_x_d   = T3_X0;
                    tube3_y_d   = T3_Y0;
                    score_d     = '0;
                    ground_d    = 1'b0;
                    flap_pend_d = 1'b0;
                    dead_cnt_d  = '0;
                    game_end_d  = 1'b0;
                end
            end
        endcase
    end

    // State registers with synchronous reset; the LFSR is seeded only here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bird_y_q    <= BIRD_Y0;
            vel_q       <= '0;
            tube1_x_q   <= T1_X0;
            tube1_y_q   <= T1_Y0;
            tube2_x_q   <= T2_X0;
            tube2_y_q   <= T2_Y0;
            tube3_x_q   <= T3_X0;
            tube3_y_q   <= T3_Y0;
            score_q     <= '0;
            ground_q    <= 1'b0;
            flap_pend_q <= 1'b0;
            dead_cnt_q  <= '0;
            game_end_q  <= 1'b0;
            lfsr_q      <= 8'hA5;
        end else begin
            state_q     <= state_d;
            bird_y_q    <= bird_y_d;
            vel_q       <= vel_d;
            tube1_x_q   <= tube1_x_d;
            tube1_y_q   <= tube1_y_d;
            tube2_x_q   <= tube2_x_d;
            tube2_y_q   <= tube2_y_d;
            tube3_x_q   <= tube3_x_d;
            tube3_y_q   <= tube3_y_d;
            score_q     <= score_d;
            ground_q    <= ground_d;
            flap_pend_q <= flap_pend_d;
            dead_cnt_q  <= dead_cnt_d;
            game_end_q  <= game_end_d;
            lfsr_q      <= lfsr_d;
        end
    end

    assign bird_y_pos  = bird_y_q;
    assign tube1_x_pos = tube1_x_q;
    assign tube2_x_pos = tube2_x_q;
    assign tube3_x_pos = tube3_x_q;
    assign tube1_y_pos = tube1_y_q;
    assign tube2_y_pos = tube2_y_q;
    assign tube3_y_pos = tube3_y_q;
    assign game_end    = game_end_q;
    assign score       = score_q;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Directed bench for flappy_game_ctrl: idle, flap physics, fall/collision, dead hold, ground, scoring.
// Inputs driven and outputs sampled on the falling clock edge.
// Expected values are hand-derived trajectories plus a reference model of the gap LFSR.
module tb_flappy_game_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       flap = 1'b0;
    logic [9:0] bird_y_pos;
    logic [9:0] tube1_x_pos, tube2_x_pos, tube3_x_pos;
    logic [9:0] tube1_y_pos, tube2_y_pos, tube3_y_pos;
    logic       game_end;
    logic [7:0] score;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] m_lfsr;
    int         exp_gap;
    int         exp_sc;

    // bird_y after k ticks following a single flap, k = 1..17 (velocities -8..+8)
    int y_tab [17] = '{232, 225, 219, 214, 210, 207, 205, 204, 204,
                       205, 207, 210, 214, 219, 225, 232, 240};

    always #5 clk = ~clk;

    flappy_game_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .frame_tick  (frame_tick),
        .flap        (flap),
        .bird_y_pos  (bird_y_pos),
        .tube1_x_pos (tube1_x_pos),
        .tube2_x_pos (tube2_x_pos),
        .tube3_x_pos (tube3_x_pos),
        .tube1_y_pos (tube1_y_pos),
        .tube2_y_pos (tube2_y_pos),
        .tube3_y_pos (tube3_y_pos),
        .game_end    (game_end),
        .score       (score)
    );

    // Reference gap generator: x^8+x^6+x^5+x^4 Fibonacci, seeded on reset, stepping every clock.
    always @(posedge clk) begin
        if (rst) m_lfsr <= 8'hA5;
        else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_init(input string tag);
        chk({tag, "_bird_y"},  32'(bird_y_pos),  240);
        chk({tag, "_t1x"},     32'(tube1_x_pos), 480);
        chk({tag, "_t2x"},     32'(tube2_x_pos), 680);
        chk({tag, "_t3x"},     32'(tube3_x_pos), 880);
        chk({tag, "_t1y"},     32'(tube1_y_pos), 240);
        chk({tag, "_t2y"},     32'(tube2_y_pos), 200);
        chk({tag, "_t3y"},     32'(tube3_y_pos), 280);
        chk({tag, "_score"},   32'(score),       0);
        chk({tag, "_game_end"}, 32'(game_end),   0);
    endtask

    // One frame: tick for a cycle, then leave room for the check cycle to complete.
    task automatic tick_n(input logic with_flap);
        frame_tick = 1'b1;
        flap       = with_flap;
        @(negedge clk);
        frame_tick = 1'b0;
        flap       = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic flap_pulse();
        flap = 1'b1;
        @(negedge clk);
        flap = 1'b0;
        @(negedge clk);
    endtask

    function automatic int fall_y(input int k);
        return (k <= 17) ? y_tab[k-1] : 240 + 8 * (k - 17);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_init("reset");

        // frame ticks in IDLE change nothing
        for (int i = 0; i < 10; i++) tick_n(1'b0);
        chk_init("idle_ticks");

        // flap from IDLE, then a flap coinciding with tick 2
        flap_pulse();
        tick_n(1'b0); chk("flap_t1_y", 32'(bird_y_pos), 232);
        tick_n(1'b1); chk("flap_t2_y", 32'(bird_y_pos), 225);
        tick_n(1'b0); chk("flap_t3_y", 32'(bird_y_pos), 217);
        tick_n(1'b0); chk("flap_t4_y", 32'(bird_y_pos), 210);
        chk("flap_t4_t1x", 32'(tube1_x_pos), 472);
        chk("flap_t4_t2x", 32'(tube2_x_pos), 672);

        // reset in the middle of play
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_init("rst_mid_play");
        tick_n(1'b0);
        chk("idle_after_rst_y", 32'(bird_y_pos), 240);

        // single flap then free fall; tube1 reaches 410 on tick 35 (no hit)
        flap_pulse();
        for (int k = 1; k <= 35; k++) begin
            tick_n(1'b0);
            chk("fall_y", 32'(bird_y_pos), fall_y(k));
            chk("fall_t1x", 32'(tube1_x_pos), 480 - 2 * k);
            chk("fall_alive", 32'(game_end), 0);
        end

        // tick 36: tube1 at 408 overlaps the falling bird
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        chk("fatal_y", 32'(bird_y_pos), 392);
        chk("fatal_t1x", 32'(tube1_x_pos), 408);
        chk("fatal_ge_edge_n", 32'(game_end), 0);
        @(negedge clk);
        chk("fatal_ge_edge_n1", 32'(game_end), 1);
        @(negedge clk);

        // DEAD: frozen outputs, flap ignored until 60 ticks elapsed
        for (int i = 1; i <= 59; i++) begin
            tick_n(1'b0);
            if (i == 3) begin
                chk("dead_frozen_y", 32'(bird_y_pos), 392);
                chk("dead_frozen_t1x", 32'(tube1_x_pos), 408);
                chk("dead_frozen_t2x", 32'(tube2_x_pos), 608);
                chk("dead_frozen_ge", 32'(game_end), 1);
            end
        end
        flap_pulse();
        chk("hold59_ge", 32'(game_end), 1);
        chk("hold59_y", 32'(bird_y_pos), 392);
        tick_n(1'b0);
        flap_pulse();
        chk_init("hold60_idle");

        // ground: tube1 parked off-screen so the bird can reach the floor
        force dut.tube1_x_q = 10'd900;
        flap_pulse();
        for (int k = 1; k <= 45; k++) tick_n(1'b0);
        chk("ground_pre_y", 32'(bird_y_pos), 464);
        chk("ground_pre_ge", 32'(game_end), 0);
        tick_n(1'b0);
        chk("ground_y", 32'(bird_y_pos), 464);
        chk("ground_ge", 32'(game_end), 1);
        chk("ground_t2x", 32'(tube2_x_pos), 588);
        release dut.tube1_x_q;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_init("rst_after_ground");

        // scoring: bird held at each approaching tube's gap centre
        flap_pulse();
        force dut.bird_y_q = 10'd240;
        exp_gap = 0;
        for (int k = 1; k <= 300; k++) begin
            if (k == 100) force dut.bird_y_q = 10'd200;
            if (k == 200) force dut.bird_y_q = 10'd280;
            if (k == 226) exp_gap = 112 + int'(m_lfsr);
            tick_n(1'b0);
            exp_sc = 0;
            if (k >= 59)  exp_sc++;
            if (k >= 159) exp_sc++;
            if (k >= 259) exp_sc++;
            chk("score", 32'(score), exp_sc);
            if (k == 58)  chk("pass_t1x_364", 32'(tube1_x_pos), 364);
            if (k == 59)  chk("pass_t1x_362", 32'(tube1_x_pos), 362);
            if (k == 225) chk("wrap_pre_t1x", 32'(tube1_x_pos), 30);
            if (k == 226) begin
                chk("wrap_t1x", 32'(tube1_x_pos), 628);
                chk("wrap_t1y", 32'(tube1_y_pos), exp_gap);
                chk("wrap_t1y_range", 32'((tube1_y_pos >= 10'd113) && (tube1_y_pos <= 10'd367)), 1);
            end
        end
        chk("score_run_ge", 32'(game_end), 0);
        chk("score_run_t2x", 32'(tube2_x_pos), 80);
        chk("score_run_t3x", 32'(tube3_x_pos), 280);
        release dut.bird_y_q;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_init("rst_end");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
